// File: rtl/yi_writer_pkg.sv
// Shared encodings and helpers for the Y-vector writer: precision codes and fixed AXI fields.
package yi_writer_pkg;

    localparam logic [1:0] PREC_FP16 = 2'd0;
    localparam logic [1:0] PREC_FP32 = 2'd1;
    localparam logic [1:0] PREC_FP64 = 2'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

    // Code 3 is reserved and behaves as fp64.
    function automatic logic [1:0] norm_prec(input logic [1:0] prec);
        return (prec == 2'd3) ? PREC_FP64 : prec;
    endfunction

    // Lanes per 64-bit word minus one; doubles as the lane-index mask.
    function automatic logic [1:0] lane_mask(input logic [1:0] prec);
        logic [1:0] mask;
        case (prec)
            PREC_FP16: mask = 2'd3;
            PREC_FP32: mask = 2'd1;
            default:   mask = 2'd0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/yi_writer_if.sv
// AXI4 write-only channel bundle (AW/W/B) used between the Y writer and the memory interconnect.
interface yi_writer_if #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64
);

    logic [0:0]              awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [0:0]              bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/yi_writer_axi_w.sv
// Single-beat AXI4 write engine: one start pulse issues AW and W together, then waits for B.
module yi_writer_axi_w
    import yi_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic                    issued_o,
    output logic                    done_o,
    output logic [1:0]              resp_o,
    yi_writer_if.master             axi
);

    localparam logic [1:0] EIdle = 2'd0;
    localparam logic [1:0] EAddr = 2'd1;
    localparam logic [1:0] EResp = 2'd2;

    logic [1:0] state_q, state_d;
    logic       awvalid_q, awvalid_d;
    logic       wvalid_q, wvalid_d;
    logic       unused_bid;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        issued_o  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            EIdle: begin
                if (start_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = EAddr;
                end
            end
            EAddr: begin
                // Each channel retires independently; both may complete in the same cycle.
                awvalid_d = awvalid_q & ~axi.awready;
                wvalid_d  = wvalid_q & ~axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    issued_o = 1'b1;
                    state_d  = EResp;
                end
            end
            EResp: begin
                if (axi.bvalid) begin
                    done_o  = 1'b1;
                    state_d = EIdle;
                end
            end
            default: state_d = EIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= EIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign resp_o      = axi.bresp;
    assign unused_bid  = axi.bid[0];

    assign axi.awid    = 1'b0;
    assign axi.awaddr  = addr_i;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = AXI_CACHE_DEF;
    assign axi.awprot  = 3'd0;
    assign axi.awqos   = 4'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = data_i;
    assign axi.wstrb   = strb_i;
    assign axi.wlast   = wvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == EResp);

endmodule

// File: rtl/yi_writer.sv
// Packs the Yi result stream into 64-bit words at the selected precision and stores them
// contiguously from Y_BASE_ADDR, one single-beat AXI write in flight at a time.
module yi_writer
    import yi_writer_pkg::*;
#(
    parameter logic [31:0] Y_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Write_Begin,
    input  logic [31:0] Write_Length,
    input  logic [1:0]  Ctrl_sig_Y,
    input  logic        Yi_valid,
    output logic        Yi_ready,
    input  logic [63:0] Yi_data,
    output logic        Write_Busy,
    output logic        Write_Done,
    output logic        Write_Error,
    yi_writer_if.master m_axi_Y
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCollect = 3'd1;
    localparam logic [2:0] StIssue   = 3'd2;
    localparam logic [2:0] StWaitB   = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [31:0]             elem_cnt_q, elem_cnt_d;
    logic [31:0]             word_cnt_q, word_cnt_d;
    logic [31:0]             len_q, len_d;
    logic [1:0]              prec_q, prec_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    err_q, err_d;

    logic                    yi_fire;
    logic                    last_elem;
    logic [1:0]              lane;
    logic                    aw_start;
    logic                    aw_issued;
    logic                    b_done;
    logic [1:0]              b_resp;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign lane      = elem_cnt_q[1:0] & lane_mask(prec_q);
    assign yi_fire   = Yi_valid & Yi_ready;
    assign last_elem = (elem_cnt_q + 32'd1) == len_q;
    assign word_addr = ADDR_WIDTH'(Y_BASE_ADDR) + (ADDR_WIDTH'(word_cnt_q) << 3);

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        prec_d     = prec_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        err_d      = err_q;
        aw_start   = 1'b0;
        case (state_q)
            StIdle: begin
                if (Write_Begin) begin
                    elem_cnt_d = 32'd0;
                    word_cnt_d = 32'd0;
                    err_d      = 1'b0;
                    len_d      = Write_Length;
                    prec_d     = norm_prec(Ctrl_sig_Y);
                    wdata_d    = '0;
                    wstrb_d    = '0;
                    state_d    = (Write_Length == 32'd0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (yi_fire) begin
                    elem_cnt_d = elem_cnt_q + 32'd1;
                    case (prec_q)
                        PREC_FP16: begin
                            wdata_d[{lane, 4'b0000} +: 16] = Yi_data[15:0];
                            wstrb_d[{lane, 1'b0} +: 2]     = 2'b11;
                        end
                        PREC_FP32: begin
                            wdata_d[{lane[0], 5'b00000} +: 32] = Yi_data[31:0];
                            wstrb_d[{lane[0], 2'b00} +: 4]     = 4'hF;
                        end
                        default: begin
                            wdata_d = Yi_data;
                            wstrb_d = 8'hFF;
                        end
                    endcase
                    // A word ships when full or when the stream ends mid-word.
                    if (lane == lane_mask(prec_q) || last_elem) begin
                        aw_start = 1'b1;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                if (aw_issued) begin
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (b_done) begin
                    err_d      = err_q | (b_resp != 2'b00);
                    word_cnt_d = word_cnt_q + 32'd1;
                    wdata_d    = '0;
                    wstrb_d    = '0;
                    state_d    = (elem_cnt_q == len_q) ? StDone : StCollect;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            elem_cnt_q <= 32'd0;
            word_cnt_q <= 32'd0;
            len_q      <= 32'd0;
            prec_q     <= PREC_FP16;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            prec_q     <= prec_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            err_q      <= err_d;
        end
    end

    assign Yi_ready    = (state_q == StCollect);
    assign Write_Busy  = (state_q == StCollect) || (state_q == StIssue) || (state_q == StWaitB);
    assign Write_Done  = (state_q == StDone);
    assign Write_Error = err_q;

    yi_writer_axi_w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_axi_w (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (aw_start),
        .addr_i   (word_addr),
        .data_i   (wdata_q),
        .strb_i   (wstrb_q),
        .issued_o (aw_issued),
        .done_o   (b_done),
        .resp_o   (b_resp),
        .axi      (m_axi_Y)
    );

endmodule

// File: tb/tb_yi_writer.sv
// Directed bench for yi_writer: a negedge AXI slave model logs writes; the main sequence checks them.
module tb_yi_writer;

    logic        clk;
    logic        rstn;
    logic        Write_Begin;
    logic [31:0] Write_Length;
    logic [1:0]  Ctrl_sig_Y;
    logic        Yi_valid;
    logic        Yi_ready;
    logic [63:0] Yi_data;
    logic        Write_Busy;
    logic        Write_Done;
    logic        Write_Error;

    yi_writer_if #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) axi_if ();

    yi_writer #(
        .Y_BASE_ADDR (32'h4000_0000),
        .ADDR_WIDTH  (48),
        .DATA_WIDTH  (64)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .Write_Begin  (Write_Begin),
        .Write_Length (Write_Length),
        .Ctrl_sig_Y   (Ctrl_sig_Y),
        .Yi_valid     (Yi_valid),
        .Yi_ready     (Yi_ready),
        .Yi_data      (Yi_data),
        .Write_Busy   (Write_Busy),
        .Write_Done   (Write_Done),
        .Write_Error  (Write_Error),
        .m_axi_Y      (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Knobs owned by the main sequence.
    int job_id   = 0;
    int aw_delay = 0;
    int err_idx  = -1;
    logic b_hold = 1'b0;

    // State owned by the slave model.
    int seen_job = 0;
    int n_aw, n_w, n_b, n_done, aw_cycles, w_cycles, unstable, ready_bad, aw_wait;
    logic aw_done, w_done, b_fire, prev_awv;
    logic [47:0] prev_addr;
    logic [47:0] log_addr [16];
    logic [63:0] log_data [16];
    logic [7:0]  log_strb [16];

    logic [63:0] el [8];

    initial begin
        axi_if.awready = 1'b0;
        axi_if.wready  = 1'b0;
        axi_if.bvalid  = 1'b0;
        axi_if.bresp   = 2'b00;
        axi_if.bid     = 1'b0;
        n_aw = 0; n_w = 0; n_b = 0; n_done = 0; aw_cycles = 0; w_cycles = 0;
        unstable = 0; ready_bad = 0; aw_wait = 0;
        aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0; prev_awv = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (job_id != seen_job) begin
                seen_job = job_id;
                n_aw = 0; n_w = 0; n_b = 0; n_done = 0; aw_cycles = 0; w_cycles = 0;
                unstable = 0; ready_bad = 0;
            end
            if (!rstn) begin
                axi_if.awready = 1'b0;
                axi_if.wready  = 1'b0;
                axi_if.bvalid  = 1'b0;
                aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0; prev_awv = 1'b0; aw_wait = 0;
            end else begin
                if (b_fire) begin
                    axi_if.bvalid = 1'b0;
                    b_fire = 1'b0;
                    n_b++;
                end
                if (aw_done && w_done && !axi_if.bvalid && !b_hold) begin
                    axi_if.bvalid = 1'b1;
                    axi_if.bresp  = (n_b == err_idx) ? 2'd2 : 2'd0;
                    aw_done = 1'b0;
                    w_done  = 1'b0;
                end
                if (axi_if.bvalid && axi_if.bready) b_fire = 1'b1;
                if (axi_if.awvalid) begin
                    aw_cycles++;
                    if (prev_awv && axi_if.awaddr != prev_addr) unstable++;
                    axi_if.awready = (aw_wait >= aw_delay);
                    if (axi_if.awready) begin
                        if (n_aw < 16) log_addr[n_aw] = axi_if.awaddr;
                        n_aw++;
                        aw_done = 1'b1;
                        aw_wait = 0;
                    end else begin
                        aw_wait++;
                    end
                end else begin
                    axi_if.awready = 1'b0;
                end
                prev_awv  = axi_if.awvalid;
                prev_addr = axi_if.awaddr;
                axi_if.wready = axi_if.wvalid;
                if (axi_if.wvalid) begin
                    w_cycles++;
                    if (n_w < 16) begin
                        log_data[n_w] = axi_if.wdata;
                        log_strb[n_w] = axi_if.wstrb;
                    end
                    n_w++;
                    w_done = 1'b1;
                end
                if (Write_Done) n_done++;
                if (Yi_ready && (axi_if.awvalid || axi_if.wvalid || axi_if.bready)) ready_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [1:0] prec, input logic [31:0] len, input int n_el);
        int t;
        job_id++;
        @(negedge clk);
        Ctrl_sig_Y   = prec;
        Write_Length = len;
        Write_Begin  = 1'b1;
        @(negedge clk);
        Write_Begin = 1'b0;
        for (int i = 0; i < n_el; i++) begin
            Yi_data  = el[i];
            Yi_valid = 1'b1;
            t = 0;
            while (!Yi_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("yi_accept_timeout", 64'(t), 64'd0);
            @(negedge clk);
        end
        Yi_valid = 1'b0;
        t = 0;
        while (!Write_Done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("done_timeout", 64'(t), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int t;
        rstn = 1'b0; Write_Begin = 1'b0; Write_Length = '0; Ctrl_sig_Y = '0;
        Yi_valid = 1'b0; Yi_data = '0;
        repeat (3) @(negedge clk);
        check("rst_yi_ready", Yi_ready, 0);
        check("rst_awvalid", axi_if.awvalid, 0);
        check("rst_wvalid", axi_if.wvalid, 0);
        check("rst_bready", axi_if.bready, 0);
        check("rst_busy", Write_Busy, 0);
        check("rst_done", Write_Done, 0);
        check("rst_error", Write_Error, 0);
        rstn = 1'b1;

        // fp64, three full words
        el = '{64'hAAAA_0000_AAAA_0001, 64'hBBBB_0000_BBBB_0002, 64'hCCCC_0000_CCCC_0003,
               64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        run_job(2'd2, 32'd3, 3);
        check("t1_naw", 64'(n_aw), 3);
        check("t1_addr0", log_addr[0], 64'h4000_0000);
        check("t1_addr1", log_addr[1], 64'h4000_0008);
        check("t1_addr2", log_addr[2], 64'h4000_0010);
        check("t1_data0", log_data[0], 64'hAAAA_0000_AAAA_0001);
        check("t1_data1", log_data[1], 64'hBBBB_0000_BBBB_0002);
        check("t1_data2", log_data[2], 64'hCCCC_0000_CCCC_0003);
        check("t1_strb0", log_strb[0], 8'hFF);
        check("t1_strb2", log_strb[2], 8'hFF);
        check("t1_ndone", 64'(n_done), 1);
        check("t1_busy_after", Write_Busy, 0);

        // fp32, partial final word; upper input bits must be ignored
        el = '{64'hDEAD_BEEF_1111_1111, 64'h2222_2222, 64'h3333_3333,
               64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        run_job(2'd1, 32'd3, 3);
        check("t2_naw", 64'(n_aw), 2);
        check("t2_data0", log_data[0], 64'h2222_2222_1111_1111);
        check("t2_strb0", log_strb[0], 8'hFF);
        check("t2_addr0", log_addr[0], 64'h4000_0000);
        check("t2_data1", log_data[1], 64'h0000_0000_3333_3333);
        check("t2_strb1", log_strb[1], 8'h0F);
        check("t2_addr1", log_addr[1], 64'h4000_0008);

        // fp16, five elements
        el = '{64'h1111, 64'h2222, 64'h3333, 64'h4444, 64'hFFFF_5555,
               64'h0, 64'h0, 64'h0};
        run_job(2'd0, 32'd5, 5);
        check("t3_naw", 64'(n_aw), 2);
        check("t3_data0", log_data[0], 64'h4444_3333_2222_1111);
        check("t3_strb0", log_strb[0], 8'hFF);
        check("t3_data1", log_data[1], 64'h0000_0000_0000_5555);
        check("t3_strb1", log_strb[1], 8'h03);
        check("t3_addr1", log_addr[1], 64'h4000_0008);

        // awready delayed three cycles; precision code 3 acts as fp64
        aw_delay = 3;
        el = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        run_job(2'd3, 32'd1, 1);
        aw_delay = 0;
        check("t4_w_cycles", 64'(w_cycles), 1);
        check("t4_aw_cycles", 64'(aw_cycles), 4);
        check("t4_addr_stable", 64'(unstable), 0);
        check("t4_ready_low", 64'(ready_bad), 0);
        check("t4_addr", log_addr[0], 64'h4000_0000);
        check("t4_data", log_data[0], 64'h0123_4567_89AB_CDEF);

        // error response on the second of three writes
        err_idx = 1;
        el = '{64'h1, 64'h2, 64'h3, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        run_job(2'd2, 32'd3, 3);
        err_idx = -1;
        check("t5_error", Write_Error, 1);
        check("t5_naw", 64'(n_aw), 3);
        check("t5_addr2", log_addr[2], 64'h4000_0010);
        check("t5_data2", log_data[2], 64'h3);
        check("t5_ndone", 64'(n_done), 1);
        check("t5_ready_low", 64'(ready_bad), 0);

        // reset while waiting on B, then a zero-length run
        job_id++;
        b_hold = 1'b1;
        @(negedge clk);
        Ctrl_sig_Y = 2'd2; Write_Length = 32'd1; Write_Begin = 1'b1;
        @(negedge clk);
        Write_Begin = 1'b0;
        check("t6_error_cleared", Write_Error, 0);
        check("t6_busy", Write_Busy, 1);
        Yi_data = 64'h77; Yi_valid = 1'b1;
        @(negedge clk);
        Yi_valid = 1'b0;
        t = 0;
        while (!axi_if.bready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t6_reach_waitb", axi_if.bready, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rst_awvalid", axi_if.awvalid, 0);
        check("t6_rst_wvalid", axi_if.wvalid, 0);
        check("t6_rst_bready", axi_if.bready, 0);
        check("t6_rst_yi_ready", Yi_ready, 0);
        check("t6_rst_busy", Write_Busy, 0);
        rstn = 1'b1;
        b_hold = 1'b0;
        job_id++;
        @(negedge clk);
        Write_Length = 32'd0; Write_Begin = 1'b1;
        @(negedge clk);
        Write_Begin = 1'b0;
        check("t6_len0_done", Write_Done, 1);
        @(negedge clk);
        check("t6_len0_done_drop", Write_Done, 0);
        check("t6_len0_no_aw", 64'(aw_cycles), 0);
        check("t6_len0_ndone", 64'(n_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
